// File: rtl/edlo_pkg.sv
// -----------------------------------------------------------------------------
// edlo_pkg
//   Shared definitions for the EDLO program sequencer:
//     - program opcodes (instruction byte bits [7:4])
//     - ALU instruction codes driven on the sequencer's inst_out port
//     - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package edlo_pkg;

  // Program opcodes
  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_HALT    = 4'h1;
  localparam logic [3:0] OP_JMP     = 4'h2;
  localparam logic [3:0] OP_LDA_IMM = 4'h3;
  localparam logic [3:0] OP_LDB_IMM = 4'h4;
  localparam logic [3:0] OP_LDA_RAM = 4'h5;
  localparam logic [3:0] OP_LDB_RAM = 4'h6;
  localparam logic [3:0] OP_ADD     = 4'h7;
  localparam logic [3:0] OP_STR     = 4'h8;

  // ALU instruction codes; 0 means "no ALU action"
  localparam logic [3:0] ALU_NONE    = 4'h0;
  localparam logic [3:0] ALU_LDA_IMM = 4'h3;
  localparam logic [3:0] ALU_LDB_IMM = 4'h4;
  localparam logic [3:0] ALU_LDA_RAM = 4'h5;
  localparam logic [3:0] ALU_LDB_RAM = 4'h6;
  localparam logic [3:0] ALU_ADD     = 4'h7;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_FETCH_OP = 3'd3,
    ST_LATCH_OP = 3'd4,
    ST_RAM_ADDR = 3'd5,
    ST_EXEC     = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

endpackage

// File: rtl/edlo_opdecode.sv
// -----------------------------------------------------------------------------
// edlo_opdecode
//   Purely combinational opcode classifier.
//   Ports:
//     opcode      in  4  opcode field of the instruction byte
//     has_operand out 1  an operand byte follows the opcode byte
//     is_ram_load out 1  operand is a data-RAM address to be read into the ALU
//     is_jump     out 1  operand is a new program counter
//     is_halt     out 1  HALT instruction
//     illegal     out 1  opcode outside the defined set
//     alu_inst    out 4  ALU instruction to issue in EXEC (0 = none)
// -----------------------------------------------------------------------------
module edlo_opdecode
  import edlo_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       has_operand,
  output logic       is_ram_load,
  output logic       is_jump,
  output logic       is_halt,
  output logic       illegal,
  output logic [3:0] alu_inst
);

  always_comb begin
    has_operand = 1'b0;
    is_ram_load = 1'b0;
    is_jump     = 1'b0;
    is_halt     = 1'b0;
    illegal     = 1'b0;
    alu_inst    = ALU_NONE;
    case (opcode)
      OP_NOP: ;
      OP_HALT: is_halt = 1'b1;
      OP_JMP: begin
        has_operand = 1'b1;
        is_jump     = 1'b1;
      end
      OP_LDA_IMM: begin
        has_operand = 1'b1;
        alu_inst    = ALU_LDA_IMM;
      end
      OP_LDB_IMM: begin
        has_operand = 1'b1;
        alu_inst    = ALU_LDB_IMM;
      end
      OP_LDA_RAM: begin
        has_operand = 1'b1;
        is_ram_load = 1'b1;
        alu_inst    = ALU_LDA_RAM;
      end
      OP_LDB_RAM: begin
        has_operand = 1'b1;
        is_ram_load = 1'b1;
        alu_inst    = ALU_LDB_RAM;
      end
      OP_ADD: alu_inst = ALU_ADD;
      OP_STR: has_operand = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/edlo_sequencer.sv
// -----------------------------------------------------------------------------
// edlo_sequencer
//   Program sequencer for the EDLO ALU. Fetches instruction and operand bytes
//   from a synchronous program memory, issues one-cycle ALU strobes, presents
//   data-RAM read addresses for RAM loads and writes the ALU result back to
//   data RAM for STR.
//   Ports:
//     clock      in   1       system clock, rising edge
//     reset      in   1       asynchronous active-high reset
//     start      in   1       begin at PC 0 (honoured only in IDLE / DONE)
//     busy       out  1       running (not IDLE, not DONE)
//     done       out  1       in DONE
//     error      out  1       last halt was caused by an illegal opcode
//     prog_addr  out  ADDR_W  program-memory address
//     prog_data  in   8       program byte (one cycle after prog_addr)
//     ram_addr   out  ADDR_W  data-RAM address
//     ram_rd     in   8       data-RAM read data (consumed by the ALU)
//     ram_we     out  1       data-RAM write strobe
//     ram_wdata  out  8       data-RAM write data (ALU result)
//     rtn_in     in   8       ALU result register
//     inst_out   out  4       ALU instruction, 0 when idle
//     data_out   out  8       immediate operand for the ALU
// -----------------------------------------------------------------------------
module edlo_sequencer
  import edlo_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rd,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        rtn_in,
  output logic [3:0]        inst_out,
  output logic [7:0]        data_out
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        operand_q, operand_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [3:0]        alu_q, alu_d;
  logic              jump_q, jump_d;
  logic              ramld_q, ramld_d;
  logic              error_q, error_d;

  logic              dec_has_operand;
  logic              dec_is_ram_load;
  logic              dec_is_jump;
  logic              dec_is_halt;
  logic              dec_illegal;
  logic [3:0]        dec_alu_inst;

  // ram_rd feeds the ALU directly; the sequencer never looks at it.
  logic              unused_ram_rd;
  assign unused_ram_rd = ^ram_rd;

  // The decoder only sees the raw program byte; its results are registered
  // in DECODE so that every output below comes from flops.
  edlo_opdecode u_opdecode (
    .opcode      (prog_data[7:4]),
    .has_operand (dec_has_operand),
    .is_ram_load (dec_is_ram_load),
    .is_jump     (dec_is_jump),
    .is_halt     (dec_is_halt),
    .illegal     (dec_illegal),
    .alu_inst    (dec_alu_inst)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    operand_d = operand_q;
    opcode_d  = opcode_q;
    alu_d     = alu_q;
    jump_d    = jump_q;
    ramld_d   = ramld_q;
    error_d   = error_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          error_d = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        opcode_d = prog_data[7:4];
        alu_d    = dec_alu_inst;
        jump_d   = dec_is_jump;
        ramld_d  = dec_is_ram_load;
        pc_d     = pc_q + ADDR_W'(1);
        if (dec_illegal) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else if (dec_is_halt) begin
          state_d = ST_DONE;
        end else if (dec_has_operand) begin
          state_d = ST_FETCH_OP;
        end else if (dec_alu_inst == ALU_ADD) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH_OP: state_d = ST_LATCH_OP;
      ST_LATCH_OP: begin
        operand_d = prog_data;
        if (jump_q) begin
          pc_d    = ADDR_W'(prog_data);
          state_d = ST_FETCH;
        end else begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ramld_q ? ST_RAM_ADDR : ST_EXEC;
        end
      end
      ST_RAM_ADDR: state_d = ST_EXEC;
      ST_EXEC:     state_d = ST_FETCH;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      operand_q <= '0;
      opcode_q  <= OP_NOP;
      alu_q     <= ALU_NONE;
      jump_q    <= 1'b0;
      ramld_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      operand_q <= operand_d;
      opcode_q  <= opcode_d;
      alu_q     <= alu_d;
      jump_q    <= jump_d;
      ramld_q   <= ramld_d;
      error_q   <= error_d;
    end
  end

  logic in_exec;
  logic is_store;
  logic is_imm;

  assign in_exec  = (state_q == ST_EXEC);
  assign is_store = (opcode_q == OP_STR);
  assign is_imm   = (alu_q == ALU_LDA_IMM) || (alu_q == ALU_LDB_IMM);

  // Reset clears state_q asynchronously, so inst_out / ram_we fall with it.
  always_comb begin
    busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done      = (state_q == ST_DONE);
    error     = error_q;
    prog_addr = pc_q;
    ram_addr  = '0;
    if ((state_q == ST_RAM_ADDR) || (in_exec && (ramld_q || is_store))) begin
      ram_addr = ADDR_W'(operand_q);
    end
    ram_we    = in_exec && is_store;
    ram_wdata = rtn_in;
    inst_out  = in_exec ? alu_q : ALU_NONE;
    data_out  = (in_exec && is_imm) ? operand_q : '0;
  end

endmodule

// File: tb/tb_edlo_sequencer.sv
module tb_edlo_sequencer;

  localparam int unsigned AW = 8;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rd;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    rtn_in;
  logic [3:0]    inst_out;
  logic [7:0]    data_out;

  always #5 clock = ~clock;

  edlo_sequencer #(.ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .rtn_in    (rtn_in),
    .inst_out  (inst_out),
    .data_out  (data_out)
  );

  int         vectors = 0;
  int         miscompares = 0;
  wr_t        exp_q[$];
  logic [7:0] prog [256];
  logic [7:0] ram  [256];
  logic [7:0] alu_a, alu_b;
  int         cyc_n;
  int         cnt_inst [16];
  int         first_inst [16];
  logic [7:0] before_raddr [16];
  logic [7:0] inst_raddr [16];
  logic [7:0] prev_paddr, prev_raddr;
  bit         saw_addr2, saw_wrap, any_inst, patch_on_ff;
  int         edges;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: observe at the falling edge, then update the memory / ALU
  // models just after the rising edge from what was observed.
  task automatic cyc();
    logic [7:0] l_pa, l_ra, l_wd, l_do, l_rd;
    logic       l_we;
    logic [3:0] l_in;
    wr_t        w;
    @(negedge clock);
    l_pa = prog_addr; l_ra = ram_addr; l_wd = ram_wdata; l_do = data_out;
    l_rd = ram_rd;    l_we = ram_we;   l_in = inst_out;
    if (l_in != 4'h0) begin
      any_inst = 1'b1;
      cnt_inst[l_in]++;
      if (first_inst[l_in] < 0) first_inst[l_in] = cyc_n;
      before_raddr[l_in] = prev_raddr;
      inst_raddr[l_in]   = l_ra;
    end
    if (busy && l_pa == 8'h02) saw_addr2 = 1'b1;
    if (prev_paddr == 8'hFF && l_pa == 8'h00) saw_wrap = 1'b1;
    if (patch_on_ff && l_pa == 8'hFF) prog[0] = 8'h10;
    if (l_we) begin
      check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("write_addr", {24'd0, l_ra}, {24'd0, w.addr});
        check("write_data", {24'd0, l_wd}, {24'd0, w.data});
      end
    end
    prev_paddr = l_pa;
    prev_raddr = l_ra;
    @(posedge clock);
    #1;
    prog_data = prog[l_pa];
    ram_rd    = ram[l_ra];
    if (l_we) ram[l_ra] = l_wd;
    case (l_in)
      4'h3: alu_a = l_do;
      4'h4: alu_b = l_do;
      4'h5: alu_a = l_rd;
      4'h6: alu_b = l_rd;
      4'h7: rtn_in = alu_a + alu_b;
      default: ;
    endcase
    cyc_n++;
  endtask

  task automatic fill_prog(input logic [7:0] v);
    for (int i = 0; i < 256; i++) prog[i] = v;
  endtask

  // Pulse start across one rising edge; returns in cycle 1 (FETCH).
  task automatic launch();
    for (int i = 0; i < 16; i++) begin
      cnt_inst[i] = 0;
      first_inst[i] = -1;
      before_raddr[i] = 8'h00;
      inst_raddr[i] = 8'h00;
    end
    saw_addr2 = 1'b0;
    saw_wrap  = 1'b0;
    any_inst  = 1'b0;
    cyc_n = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Returns the number of rising edges after the start edge at which done
  // was first seen, or -1 if the budget ran out.
  task automatic run(input int budget, output int e);
    e = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        e = cyc_n - 1;
        break;
      end
      cyc();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_data = 8'h00; ram_rd = 8'h00;
    rtn_in = 8'h00; alu_a = 8'h00; alu_b = 8'h00;
    prev_paddr = 8'h00; prev_raddr = 8'h00; patch_on_ff = 1'b0; cyc_n = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    fill_prog(8'hF0);

    // Reset state
    cyc(); cyc();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_inst", {28'd0, inst_out}, 32'd0);
    check("rst_we", {31'd0, ram_we}, 32'd0);
    check("rst_paddr", {24'd0, prog_addr}, 32'd0);
    check("rst_raddr", {24'd0, ram_addr}, 32'd0);
    reset = 1'b0;
    cyc();

    // LDA #5, LDB #7, ADD, STR 0x10, HALT
    fill_prog(8'hF0);
    prog[0] = 8'h30; prog[1] = 8'h05; prog[2] = 8'h40; prog[3] = 8'h07;
    prog[4] = 8'h70; prog[5] = 8'h80; prog[6] = 8'h10; prog[7] = 8'h10;
    exp_q.push_back('{addr: 8'h10, data: 8'h0C});
    launch();
    check("t1_busy", {31'd0, busy}, 32'd1);
    run(60, edges);
    check("t1_cycles", edges, 32'd20);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_scoreboard_empty", exp_q.size(), 32'd0);
    check("t1_ram10", {24'd0, ram[8'h10]}, 32'h0C);
    check("t1_add_count", cnt_inst[7], 32'd1);
    check("t1_busy_done", {31'd0, busy}, 32'd0);

    // LDA [0x20], LDB [0x21], ADD, STR 0x22, HALT
    fill_prog(8'hF0);
    ram[8'h20] = 8'h11; ram[8'h21] = 8'h22;
    prog[0] = 8'h50; prog[1] = 8'h20; prog[2] = 8'h60; prog[3] = 8'h21;
    prog[4] = 8'h70; prog[5] = 8'h80; prog[6] = 8'h22; prog[7] = 8'h10;
    exp_q.push_back('{addr: 8'h22, data: 8'h33});
    launch();
    run(60, edges);
    check("t2_cycles", edges, 32'd22);
    check("t2_ram22", {24'd0, ram[8'h22]}, 32'h33);
    check("t2_scoreboard_empty", exp_q.size(), 32'd0);
    check("t2_lda_count", cnt_inst[5], 32'd1);
    check("t2_lda_cycle", first_inst[5], 32'd6);
    check("t2_lda_addr_before", {24'd0, before_raddr[5]}, 32'h20);
    check("t2_lda_addr_held", {24'd0, inst_raddr[5]}, 32'h20);
    check("t2_ldb_count", cnt_inst[6], 32'd1);
    check("t2_ldb_cycle", first_inst[6], 32'd12);
    check("t2_ldb_addr_before", {24'd0, before_raddr[6]}, 32'h21);

    // JMP 4 skips bytes 2-3
    fill_prog(8'hF0);
    prog[0] = 8'h20; prog[1] = 8'h04; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'h10;
    launch();
    run(30, edges);
    check("t3_cycles", edges, 32'd6);
    check("t3_addr2_seen", {31'd0, saw_addr2}, 32'd0);
    check("t3_pc_after", {24'd0, prog_addr}, 32'h05);
    check("t3_no_inst", {31'd0, any_inst}, 32'd0);

    // Illegal opcode, then a clean restart
    fill_prog(8'hF0);
    prog[0] = 8'hA0;
    launch();
    run(20, edges);
    check("t4_cycles", edges, 32'd2);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_no_inst", {31'd0, any_inst}, 32'd0);
    prog[0] = 8'h10;
    launch();
    check("t4_error_cleared", {31'd0, error}, 32'd0);
    run(20, edges);
    check("t4_halt_cycles", edges, 32'd2);
    check("t4_halt_error", {31'd0, error}, 32'd0);

    // JMP 0xF0, NOP sled to 0xFF, wrap to 0x00 which then holds HALT
    fill_prog(8'h00);
    prog[0] = 8'h20; prog[1] = 8'hF0;
    patch_on_ff = 1'b1;
    launch();
    run(100, edges);
    patch_on_ff = 1'b0;
    check("t5_cycles", edges, 32'd38);
    check("t5_wrap", {31'd0, saw_wrap}, 32'd1);
    check("t5_pc_after", {24'd0, prog_addr}, 32'h01);
    check("t5_error", {31'd0, error}, 32'd0);

    // Reset during the LDA # EXEC cycle
    fill_prog(8'hF0);
    prog[0] = 8'h30; prog[1] = 8'h05; prog[2] = 8'h10;
    launch();
    cyc(); cyc(); cyc(); cyc();
    check("t6_exec_inst", {28'd0, inst_out}, 32'd3);
    check("t6_exec_data", {24'd0, data_out}, 32'h05);
    reset = 1'b1;
    #1;
    check("t6_rst_inst", {28'd0, inst_out}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_done", {31'd0, done}, 32'd0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("t6_no_strobe", cnt_inst[3], 32'd0);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);
    check("t6_idle_done", {31'd0, done}, 32'd0);
    check("t6_idle_pc", {24'd0, prog_addr}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/edlo_sequencer.md
# edlo_sequencer

Program sequencer that drives the ALU's 4-bit instruction port. It fetches instruction bytes from program memory, fetches operand bytes where an instruction has one, and issues one-cycle ALU strobes with matching `data_out` or data-RAM reads. It also writes the ALU result back to data RAM. It sits between program ROM, data RAM and the ALU, replacing hand-driven `INST` stimulus.

## Interface
- `ADDR_W`, 8: program-counter and data-RAM address width.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  begin execution at PC 0; sampled only in IDLE or DONE.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high while in DONE.
- `error`  out  1  high in DONE when the halt was caused by an illegal opcode.
- `prog_addr`  out  ADDR_W  program-memory address.
- `prog_data`  in  8  program byte; synchronous memory, valid one cycle after `prog_addr`.
- `ram_addr`  out  ADDR_W  data-RAM address.
- `ram_rd`  in  8  data-RAM read data; valid one cycle after `ram_addr`; wired to the ALU's RAM input.
- `ram_we`  out  1  data-RAM write strobe.
- `ram_wdata`  out  8  write data; equals `rtn_in`.
- `rtn_in`  in  8  ALU result register.
- `inst_out`  out  4  ALU instruction; 0 whenever no ALU action is intended.
- `data_out`  out  8  immediate operand presented to the ALU data input.

## Operation
- Instruction byte: opcode is bits [7:4]; bits [3:0] are ignored.
- Opcodes and operands:
  - 0 NOP.
  - 1 HALT.
  - 2 JMP tgt.
  - 3 LDA #imm.
  - 4 LDB #imm.
  - 5 LDA [addr].
  - 6 LDB [addr].
  - 7 ADD.
  - 8 STR [addr].
- Opcodes 2–6 and 8 take one operand byte, which follows the opcode byte.
- Opcodes 9–F are illegal: enter DONE with `error`=1.
- States: IDLE, FETCH, DECODE, FETCH_OP, LATCH_OP, RAM_ADDR, EXEC, DONE.
- State transitions:
  - IDLE/DONE + `start` → FETCH. On entry, `pc`←0 and `error`←0.
  - FETCH: `prog_addr`=`pc` → DECODE.
  - DECODE: latch the opcode from `prog_data`; `pc`←`pc`+1.
    - NOP → FETCH.
    - HALT or illegal → DONE.
    - Operand opcodes → FETCH_OP.
    - ADD → EXEC.
  - FETCH_OP: `prog_addr`=`pc` → LATCH_OP.
  - LATCH_OP: `operand`←`prog_data`.
    - JMP: `pc`←`operand` → FETCH.
    - Opcodes 5 and 6: `pc`←`pc`+1 → RAM_ADDR.
    - All others: `pc`←`pc`+1 → EXEC.
  - RAM_ADDR: `ram_addr`=`operand` → EXEC.
  - EXEC: one cycle → FETCH.
    - LDA #/LDB #: `inst_out`=3/4, `data_out`=`operand`.
    - LDA []/LDB []: `inst_out`=5/6, `ram_addr` held at `operand`.
    - ADD: `inst_out`=7.
    - STR: `ram_addr`=`operand`, `ram_we`=1.
- `inst_out` is nonzero only in EXEC.
- `ram_we` is high only in EXEC for STR.
- `pc` is ADDR_W bits and wraps 0xFF→0x00 silently.
- `start` while busy is ignored.
- Reset values: state IDLE, `pc`=0, and all outputs 0, including `inst_out`, `ram_we` and `error`.

## Timing
- All outputs are decoded from registered state, `pc` and `operand`. No combinational path runs from `prog_data`, `ram_rd` or `rtn_in` to any output except `ram_wdata`.
- Cycles per instruction, counted from FETCH entry:
  - NOP: 2.
  - HALT: 2.
  - ADD: 3.
  - JMP: 4.
  - LDA #, LDB #, STR: 5.
  - LDA [], LDB []: 6.
- The `start` edge counts as cycle 0; FETCH occupies cycle 1.
- The ALU captures on the EXEC→FETCH edge. `rtn_in` is valid from the following cycle, so ADD followed directly by STR stores the new sum.
- Reset asserted mid-instruction:
  - `inst_out` and `ram_we` drop to 0 asynchronously.
  - No partial write occurs after reset assertion.
  - State returns to IDLE.

## Structure
- Shared package `edlo_pkg` holds:
  - opcode constants `OP_NOP`…`OP_STR`;
  - ALU instruction constants `ALU_LDA_IMM`=3, `ALU_LDB_IMM`=4, `ALU_LDA_RAM`=5, `ALU_LDB_RAM`=6, `ALU_ADD`=7;
  - the state enum.
- One combinational sub-module, `edlo_opdecode`, maps an opcode to `has_operand`, `is_ram_load`, `is_jump`, `is_halt`, `illegal` and `alu_inst`.

## Test plan
- Program 30 05 40 07 70 80 10 10, `start` → `ram_we` with `ram_addr`=0x10, `ram_wdata`=0x0C. `done` high 20 cycles after the `start` edge; `error`=0.
- RAM[0x20]=0x11, RAM[0x21]=0x22; program 50 20 60 21 70 80 22 10 → RAM[0x22]=0x33. `inst_out`=5 and 6 each last exactly one cycle, one cycle after their `ram_addr`.
- Program 20 04 00 00 10 → PC jumps to 4 and byte 2 is never fetched; `done` after 6 cycles.
- Program A0 → `done`=1, `error`=1, `inst_out` never nonzero. A following `start` clears `error`.
- NOP sled to 0xFF, then wrap to 0x00 = 10 → `prog_addr` goes 0xFF→0x00 and `done` asserts. Separately, `reset` pulsed during the LDA # EXEC cycle → `inst_out`=0 immediately, IDLE, `busy`=0.
